// File: rtl/sys_timer_pkg.sv
// Shared CPU-side typedefs for the system timer: register offsets and register layouts.
package pkg_cpu_typedefs;

    localparam logic [3:0] TMR_CTRL_OFS   = 4'h0;
    localparam logic [3:0] TMR_COUNT_OFS  = 4'h4;
    localparam logic [3:0] TMR_CMP_OFS    = 4'h8;
    localparam logic [3:0] TMR_STATUS_OFS = 4'hC;

    localparam int TMR_PRESC_WIDTH = 8;

    typedef struct packed {
        logic [TMR_PRESC_WIDTH-1:0] presc;
        logic                       ie;
        logic                       en;
    } tmr_ctrl_reg_t;

    typedef struct packed {
        logic ovf;
        logic match;
    } tmr_status_reg_t;

endpackage

// File: rtl/sys_timer_prescaler.sv
// Prescaler for sys_timer: one-cycle tick every presc+1 enabled cycles.
module sys_timer_prescaler
    import pkg_cpu_typedefs::*;
(
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       en,
    input  logic [TMR_PRESC_WIDTH-1:0] presc,
    input  logic                       restart,
    output logic                       tick
);

    logic [TMR_PRESC_WIDTH-1:0] cnt_q;

    assign tick = en && (cnt_q == presc);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else if (!en || restart || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TMR_PRESC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sys_timer.sv
// Memory-mapped 32-bit system timer: prescaler, counter, compare/overflow flags, level IRQ.
// Optional macro SYS_TIMER_AUTO_RELOAD_EN: counter reloads to 0 on a compare match.
module sys_timer
    import pkg_cpu_typedefs::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0001_0000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  mem_wr_en,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  tmr_sel,
    output logic [DATA_WIDTH-1:0] tmr_rd_data,
    output logic                  tmr_irq
);

    tmr_ctrl_reg_t   ctrl_q, ctrl_d;
    tmr_status_reg_t status_q, status_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
    logic                  irq_d;

    logic [3:0] reg_ofs;
    logic       wr_ctrl, wr_count, wr_cmp, wr_status;
    logic       restart, tick, match_hit, ovf_hit;
    logic [1:0] unused_addr_bits;

    assign tmr_sel          = (mem_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign reg_ofs          = {mem_addr[3:2], 2'b00};
    assign unused_addr_bits = mem_addr[1:0];

    assign wr_ctrl   = mem_wr_en && tmr_sel && (reg_ofs == TMR_CTRL_OFS);
    assign wr_count  = mem_wr_en && tmr_sel && (reg_ofs == TMR_COUNT_OFS);
    assign wr_cmp    = mem_wr_en && tmr_sel && (reg_ofs == TMR_CMP_OFS);
    assign wr_status = mem_wr_en && tmr_sel && (reg_ofs == TMR_STATUS_OFS);

    // Reloading COUNT or changing the division ratio realigns the tick phase.
    assign restart = wr_count ||
                     (wr_ctrl && (mem_data_in[15:8] != ctrl_q.presc));

    sys_timer_prescaler u_prescaler (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (ctrl_q.en),
        .presc     (ctrl_q.presc),
        .restart   (restart),
        .tick      (tick)
    );

    assign match_hit = tick && (count_q == cmp_q);
    assign ovf_hit   = tick && (&count_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl_d   = ctrl_q;
        count_d  = count_q;
        cmp_d    = cmp_q;
        status_d = status_q;

        if (tick) begin
`ifdef SYS_TIMER_AUTO_RELOAD_EN
            if (match_hit) count_d = '0;
            else           count_d = count_q + DATA_WIDTH'(1);
`else
            count_d = count_q + DATA_WIDTH'(1);
`endif
        end

        if (wr_ctrl) begin
            ctrl_d.en    = mem_data_in[0];
            ctrl_d.ie    = mem_data_in[1];
            ctrl_d.presc = mem_data_in[15:8];
        end
        if (wr_count) count_d = mem_data_in;
        if (wr_cmp)   cmp_d   = mem_data_in;

        // Hardware set takes priority over a simultaneous write-1-to-clear.
        status_d.match = (status_q.match & ~(wr_status & mem_data_in[0])) | match_hit;
        status_d.ovf   = (status_q.ovf   & ~(wr_status & mem_data_in[1])) | ovf_hit;

        irq_d = ctrl_d.ie & status_d.match;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ctrl_q   <= '0;
            count_q  <= '0;
            cmp_q    <= '0;
            status_q <= '0;
            tmr_irq  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
            tmr_irq  <= irq_d;
        end
    end

    always_comb begin
        tmr_rd_data = '0;
        if (tmr_sel) begin
            unique case (reg_ofs)
                TMR_CTRL_OFS:   tmr_rd_data = DATA_WIDTH'({ctrl_q.presc, 6'b0, ctrl_q.ie, ctrl_q.en});
                TMR_COUNT_OFS:  tmr_rd_data = count_q;
                TMR_CMP_OFS:    tmr_rd_data = cmp_q;
                TMR_STATUS_OFS: tmr_rd_data = DATA_WIDTH'(status_q);
                default:        tmr_rd_data = '0;
            endcase
        end
    end

endmodule
